unary_mac_scheduler: RTL and testbench

UNARY_MAC_SCHEDULER -- requirements
Module: unary_mac_scheduler

---
 rtl/unary_mac_scheduler.sv | 162 ++++++++++++++++
 tb/tb_unary_mac_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_mac_scheduler.sv
// unary_mac_scheduler: round-robin front end for one shared unary/binary MAC.
// One request is in flight at a time. It is accepted in IDLE, issued for a
// single cycle, then waited on under a watchdog. The result (or a timeout
// error) is held in RESP until the downstream side takes it.
module unary_mac_scheduler #(
    parameter int unsigned SIZE    = 3,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = (1 << SIZE) + 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*SIZE-1:0]    req_a,
    input  logic [NREQ*SIZE-1:0]    req_b,
    input  logic [NREQ*SIZE-1:0]    req_c,
    output logic [NREQ-1:0]         req_accept,
    output logic                    mac_valid,
    output logic [SIZE-1:0]         mac_a,
    output logic [SIZE-1:0]         mac_b,
    output logic [SIZE-1:0]         mac_c,
    input  logic                    mac_ready,
    input  logic [2*SIZE-1:0]       mac_out,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*SIZE-1:0]       rsp_out,
    output logic                    rsp_err,
    input  logic                    rsp_ready,
    output logic                    busy
);

    localparam int unsigned IDW = $clog2(NREQ);
    // Wide enough to hold TIMEOUT itself, the largest value the watchdog compares against.
    localparam int unsigned WDW = $clog2(TIMEOUT + 2);
    localparam logic [WDW-1:0] TimeoutCnt = WDW'(TIMEOUT);
    localparam logic [IDW-1:0] LastId     = IDW'(NREQ - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [SIZE-1:0]   a_q, a_d;
    logic [SIZE-1:0]   b_q, b_d;
    logic [SIZE-1:0]   c_q, c_d;
    logic [WDW-1:0]    wdog_q, wdog_d;
    logic [2*SIZE-1:0] rsp_out_q, rsp_out_d;
    logic              rsp_err_q, rsp_err_d;

    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand;
    logic [WDW-1:0]    wdog_inc;

    // Round-robin pick: first asserted requester at or after ptr_q, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // State and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            wdog_q    <= '0;
            rsp_out_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            wdog_q    <= wdog_d;
            rsp_out_q <= rsp_out_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign wdog_inc = wdog_q + 1'b1;

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        wdog_d    = wdog_q;
        rsp_out_d = rsp_out_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    a_d     = req_a[grant_idx*SIZE +: SIZE];
                    b_d     = req_b[grant_idx*SIZE +: SIZE];
                    c_d     = req_c[grant_idx*SIZE +: SIZE];
                    id_d    = grant_idx;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // mac_ready is deliberately not looked at here; it may be stale.
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                // A completing MAC beats a watchdog expiring in the same cycle.
                if (mac_ready) begin
                    rsp_out_d = mac_out;
                    rsp_err_d = 1'b0;
                    state_d   = StResp;
                end else if (wdog_inc >= TimeoutCnt) begin
                    rsp_out_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    ptr_d   = (id_q == LastId) ? '0 : id_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; the accept pulse is also gated by reset since it is combinational.
    always_comb begin
        req_accept = '0;
        if (reset_n && (state_q == StIdle) && grant_found) begin
            req_accept[grant_idx] = 1'b1;
        end
        mac_valid = (state_q == StIssue);
        mac_a     = a_q;
        mac_b     = b_q;
        mac_c     = c_q;
        rsp_valid = (state_q == StResp);
        rsp_id    = id_q;
        rsp_out   = rsp_out_q;
        rsp_err   = rsp_err_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_unary_mac_scheduler.sv
// Directed bench for unary_mac_scheduler with a small MAC model that can be
// ready after a programmable delay, never ready, or permanently ready.
module tb_unary_mac_scheduler;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [11:0] req_a, req_b, req_c;
    logic [3:0]  req_accept;
    logic        mac_valid;
    logic [2:0]  mac_a, mac_b, mac_c;
    logic        mac_ready;
    logic [5:0]  mac_out;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [5:0]  rsp_out;
    logic        rsp_err;
    logic        rsp_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // MAC model: mode 0 = ready mac_delay cycles after mac_valid, 1 = never, 2 = always.
    int          mac_mode;
    int          mac_delay;
    int          mcnt;
    logic [5:0]  res;

    unary_mac_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .req_accept (req_accept),
        .mac_valid  (mac_valid),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_c      (mac_c),
        .mac_ready  (mac_ready),
        .mac_out    (mac_out),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_out    (rsp_out),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcnt <= 0;
            res  <= '0;
        end else if (mac_valid) begin
            mcnt <= 1;
            res  <= {3'b0, mac_a} * {3'b0, mac_b} + {3'b0, mac_c};
        end else if (mcnt != 0) begin
            mcnt <= (mcnt >= mac_delay) ? 0 : mcnt + 1;
        end
    end

    assign mac_ready = (mac_mode == 2) || (mac_mode == 0 && mcnt != 0 && mcnt == mac_delay);
    assign mac_out   = res;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until rsp_valid, counting cycles and mac_valid pulses seen on the way.
    task automatic wait_rsp(input int limit, output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (rsp_valid !== 1'b1 && n < limit) begin
            step();
            n++;
            if (mac_valid) pulses++;
        end
    endtask

    task automatic wait_accept(input int limit, output logic [3:0] acc);
        int n;
        n = 0;
        while (req_accept == 4'b0 && n < limit) begin
            step();
            n++;
        end
        acc = req_accept;
    endtask

    logic [3:0] exp_g [4];
    logic [3:0] acc;
    int         n, pulses;

    initial begin
        exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        rsp_ready = 1'b1;
        mac_mode  = 0;
        mac_delay = 8;
        repeat (2) step();

        // Everything quiet under reset, even with requests pending.
        req_valid = 4'b1111;
        #1;
        check_eq("rst_accept", req_accept, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mac_valid", mac_valid, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_rsp_out", rsp_out, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_mac_a", mac_a, 0);
        req_valid = '0;
        reset_n = 1'b1;
        step();

        // Single request from requester 1: 7*7+7 = 56.
        req_a = {3'd1, 3'd2, 3'd7, 3'd4};
        req_b = {3'd5, 3'd6, 3'd7, 3'd3};
        req_c = {3'd2, 3'd3, 3'd7, 3'd5};
        req_valid = 4'b0010;
        #1;
        check_eq("single_accept", req_accept, 4'b0010);
        check_eq("single_idle_busy", busy, 0);
        step();
        req_valid = '0;
        check_eq("single_mac_valid", mac_valid, 1);
        check_eq("single_mac_a", mac_a, 7);
        check_eq("single_mac_b", mac_b, 7);
        check_eq("single_mac_c", mac_c, 7);
        check_eq("single_issue_accept", req_accept, 0);
        check_eq("single_busy", busy, 1);
        step();
        check_eq("single_wait_mac_valid", mac_valid, 0);
        check_eq("single_wait_mac_a", mac_a, 7);
        wait_rsp(30, n, pulses);
        check_eq("single_latency", n, 8);
        check_eq("single_extra_pulses", pulses, 0);
        check_eq("single_rsp_id", rsp_id, 1);
        check_eq("single_rsp_out", rsp_out, 56);
        check_eq("single_rsp_err", rsp_err, 0);
        step();
        check_eq("single_done_busy", busy, 0);

        // Contention after reset: 0101 alternates 0,2,0,2.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        mac_delay = 2;
        req_valid = 4'b0101;
        #1;
        for (int g = 0; g < 4; g++) begin
            wait_accept(40, acc);
            check_eq($sformatf("grant%0d", g), acc, exp_g[g]);
            step();
        end
        req_valid = '0;
        wait_rsp(20, n, pulses);
        check_eq("cont_last_id", rsp_id, 2);
        step();

        // Backpressure on requester 3 (3*2+1 = 7) while requester 0 waits.
        req_a = {3'd3, 3'd0, 3'd0, 3'd5};
        req_b = {3'd2, 3'd0, 3'd0, 3'd5};
        req_c = {3'd1, 3'd0, 3'd0, 3'd5};
        rsp_ready = 1'b0;
        req_valid = 4'b1001;
        #1;
        check_eq("bp_accept", req_accept, 4'b1000);
        step();
        req_valid = 4'b0001;
        wait_rsp(20, n, pulses);
        check_eq("bp_rsp_id", rsp_id, 3);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp_valid%0d", i), rsp_valid, 1);
            check_eq($sformatf("bp_out%0d", i), rsp_out, 7);
            check_eq($sformatf("bp_accept%0d", i), req_accept, 0);
            check_eq($sformatf("bp_mac_valid%0d", i), mac_valid, 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_hold_valid", rsp_valid, 1);
        check_eq("bp_hold_out", rsp_out, 7);
        mac_mode = 1;
        step();
        // Pointer wrapped 3 -> 0; accept comes right after the handshake.
        check_eq("bp_after_valid", rsp_valid, 0);
        check_eq("wrap_accept", req_accept, 4'b0001);

        // Timeout on requester 0 with MAC never ready.
        step();
        req_valid = '0;
        check_eq("to_mac_valid", mac_valid, 1);
        check_eq("to_mac_a", mac_a, 5);
        wait_rsp(30, n, pulses);
        check_eq("to_latency", n, 13);
        check_eq("to_rsp_err", rsp_err, 1);
        check_eq("to_rsp_out", rsp_out, 0);
        check_eq("to_rsp_id", rsp_id, 0);
        step();

        // Stale ready: MAC always ready, requester 1 (5*6+1 = 31).
        req_a = {3'd0, 3'd6, 3'd5, 3'd0};
        req_b = {3'd0, 3'd0, 3'd6, 3'd0};
        req_c = {3'd0, 3'd0, 3'd1, 3'd0};
        mac_mode = 2;
        req_valid = 4'b0011;
        #1;
        check_eq("stale_accept", req_accept, 4'b0010);
        step();
        req_valid = '0;
        check_eq("stale_mac_valid", mac_valid, 1);
        step();
        check_eq("stale_pulse_len", mac_valid, 0);
        check_eq("stale_early_rsp", rsp_valid, 0);
        step();
        check_eq("stale_rsp_valid", rsp_valid, 1);
        check_eq("stale_rsp_out", rsp_out, 31);
        check_eq("stale_rsp_id", rsp_id, 1);
        check_eq("stale_mac_valid2", mac_valid, 0);
        step();
        check_eq("stale_no_reissue", mac_valid, 0);
        check_eq("stale_idle", busy, 0);

        // Reset while in WAIT on requester 2.
        mac_mode = 1;
        req_valid = 4'b0100;
        #1;
        check_eq("rw_accept", req_accept, 4'b0100);
        repeat (3) step();
        check_eq("rw_in_wait", busy, 1);
        check_eq("rw_wait_mac_a", mac_a, 6);
        reset_n = 1'b0;
        #1;
        check_eq("rw_busy", busy, 0);
        check_eq("rw_mac_valid", mac_valid, 0);
        check_eq("rw_mac_a", mac_a, 0);
        check_eq("rw_rsp_valid", rsp_valid, 0);
        check_eq("rw_rsp_out", rsp_out, 0);
        check_eq("rw_rsp_id", rsp_id, 0);
        check_eq("rw_accept_rst", req_accept, 0);
        step();
        step();
        req_valid = 4'b1000;
        reset_n = 1'b1;
        #1;
        check_eq("rw_post_accept", req_accept, 4'b1000);
        check_eq("rw_post_rsp", rsp_valid, 0);
        step();
        check_eq("rw_post_issue", mac_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
